// File: rtl/sdram_block_copier_if.sv
// Avalon-MM master bus between the block copier and the SDRAM controller.
// The master drives the request side; the slave returns readdata, readdatavalid and waitrequest.
interface sdram_block_copier_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 16
);
    logic [ADDR_W-1:0]   address;
    logic                read;
    logic                write;
    logic [DATA_W-1:0]   writedata;
    logic [DATA_W/8-1:0] byteenable;
    logic [DATA_W-1:0]   readdata;
    logic                readdatavalid;
    logic                waitrequest;

    modport master (
        output address, read, write, writedata, byteenable,
        input  readdata, readdatavalid, waitrequest
    );

    modport slave (
        input  address, read, write, writedata, byteenable,
        output readdata, readdatavalid, waitrequest
    );
endinterface

// File: rtl/sdram_block_copier.sv
// Copies NUM_WORDS words SRC_BASE->DST_BASE (XOR_MASK applied) in CHUNK-word bursts; done when finished.
// Latency is slave-dependent; read/write requests hold stable while waitrequest is high.
module sdram_block_copier #(
    parameter int                ADDR_W    = 32,
    parameter int                DATA_W    = 16,
    parameter logic [ADDR_W-1:0] SRC_BASE  = 32'h0000_0000,
    parameter logic [ADDR_W-1:0] DST_BASE  = 32'h0010_0000,
    parameter int                NUM_WORDS = 1024,
    parameter int                CHUNK     = 16,
    parameter logic [DATA_W-1:0] XOR_MASK  = 16'h0000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    output logic                 done,
    output logic [3:0]           state,
    sdram_block_copier_if.master avm
);
    localparam int                IW     = $clog2(CHUNK);
    localparam int                CW     = IW + 1;
    localparam logic [ADDR_W-1:0] STRIDE = ADDR_W'(DATA_W / 8);

    typedef enum logic [3:0] {
        IDLE = 4'd0,
        RD   = 4'd1,
        WR   = 4'd2,
        FIN  = 4'd3
    } state_t;

    state_t            state_q, state_d;
    logic              start_q;
    logic              done_q, done_d;
    logic [15:0]       remaining_q, remaining_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]     issued_q, issued_d;
    logic [CW-1:0]     received_q, received_d;
    logic [CW-1:0]     written_q, written_d;
    logic [DATA_W-1:0] buf_mem_q [CHUNK];

    logic [CW-1:0]     n;
    logic              buf_we;
    logic              rd_c, wr_c;
    logic [ADDR_W-1:0] addr_c;
    logic [DATA_W-1:0] wdata_c;

    // Words in the current chunk: a full CHUNK, or whatever is left at the tail.
    assign n      = (remaining_q >= 16'(CHUNK)) ? CW'(CHUNK) : remaining_q[CW-1:0];
    assign buf_we = (state_q == RD) && avm.readdatavalid && (received_q != n);

    always_comb begin
        state_d     = state_q;
        done_d      = done_q;
        remaining_d = remaining_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        issued_d    = issued_q;
        received_d  = received_q;
        written_d   = written_q;
        rd_c        = 1'b0;
        wr_c        = 1'b0;
        addr_c      = '0;
        wdata_c     = '0;
        case (state_q)
            IDLE: begin
                if (start && !start_q) begin
                    done_d      = 1'b0;
                    remaining_d = 16'(NUM_WORDS);
                    rd_ptr_d    = SRC_BASE;
                    wr_ptr_d    = DST_BASE;
                    issued_d    = '0;
                    received_d  = '0;
                    written_d   = '0;
                    state_d     = RD;
                end
            end
            RD: begin
                if (issued_q != n) begin
                    rd_c   = 1'b1;
                    addr_c = rd_ptr_q + ADDR_W'(issued_q) * STRIDE;
                    if (!avm.waitrequest) issued_d = issued_q + CW'(1);
                end
                if (buf_we) received_d = received_q + CW'(1);
                if (received_q == n) state_d = WR;
            end
            WR: begin
                wr_c    = 1'b1;
                addr_c  = wr_ptr_q + ADDR_W'(written_q) * STRIDE;
                wdata_c = buf_mem_q[written_q[IW-1:0]];
                if (!avm.waitrequest) begin
                    if (written_q + CW'(1) == n) begin
                        remaining_d = remaining_q - 16'(n);
                        rd_ptr_d    = rd_ptr_q + ADDR_W'(n) * STRIDE;
                        wr_ptr_d    = wr_ptr_q + ADDR_W'(n) * STRIDE;
                        issued_d    = '0;
                        received_d  = '0;
                        written_d   = '0;
                        state_d     = (remaining_q == 16'(n)) ? FIN : RD;
                    end else begin
                        written_d = written_q + CW'(1);
                    end
                end
            end
            FIN: begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            start_q     <= 1'b0;
            done_q      <= 1'b0;
            remaining_q <= '0;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            issued_q    <= '0;
            received_q  <= '0;
            written_q   <= '0;
        end else begin
            state_q     <= state_d;
            start_q     <= start;
            done_q      <= done_d;
            remaining_q <= remaining_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            issued_q    <= issued_d;
            received_q  <= received_d;
            written_q   <= written_d;
        end
    end

    // Chunk buffer is pure storage; every slot is rewritten before it is read.
    always_ff @(posedge clk) begin
        if (buf_we) buf_mem_q[received_q[IW-1:0]] <= avm.readdata ^ XOR_MASK;
    end

    assign avm.read       = rd_c;
    assign avm.write      = wr_c;
    assign avm.address    = addr_c;
    assign avm.writedata  = wdata_c;
    assign avm.byteenable = '1;
    assign done           = done_q;
    assign state          = state_q;
endmodule

// File: tb/tb_sdram_block_copier.sv
// Directed bench: two copier instances against an Avalon SDRAM slave model with optional random stalls.
module tb_sdram_block_copier;
    localparam logic [31:0] DST = 32'h0010_0000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_r   [2];
    logic       start_r [2];
    logic       done_w  [2];
    logic [3:0] state_w [2];
    int checks = 0;
    int failures = 0;

    sdram_block_copier_if #(.ADDR_W(32), .DATA_W(16)) bus0 ();
    sdram_block_copier_if #(.ADDR_W(32), .DATA_W(16)) bus1 ();

    sdram_block_copier #(.NUM_WORDS(32), .CHUNK(16), .XOR_MASK(16'h0000)) dut0 (
        .clk(clk), .reset(rst_r[0]), .start(start_r[0]), .done(done_w[0]),
        .state(state_w[0]), .avm(bus0.master));
    sdram_block_copier #(.NUM_WORDS(5), .CHUNK(4), .XOR_MASK(16'hFFFF)) dut1 (
        .clk(clk), .reset(rst_r[1]), .start(start_r[1]), .done(done_w[1]),
        .state(state_w[1]), .avm(bus1.master));

    // Slave model state; word index = {addr[20], addr[10:1]} separates src and dst regions.
    logic [15:0] mem [2][2048];
    bit          mode_rand [2];
    bit          spur [2];
    int          cyc = 0;
    logic [15:0] pd_dat [2][8];
    int          pd_due [2][8];
    int          ph [2], pc [2];
    int          n_rd [2], n_wr [2], wr_k [2], drise [2];
    bit          prs [2], pws [2];
    logic [31:0] pa [2];
    logic [15:0] pwd [2];
    logic [31:0] seq [2];
    logic [3:0]  pst [2];
    logic        pdn [2];
    logic [31:0] a_s [2];
    logic        r_s [2], w_s [2], wq [2], rv [2];
    logic [15:0] d_s [2], rd_s [2];

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int idx(logic [31:0] a);
        return int'({a[20], a[10:1]});
    endfunction

    task automatic slave_step(int g);
        int lat;
        int j;
        if (rst_r[g]) begin
            pc[g] = 0; prs[g] = 0; pws[g] = 0;
            wq[g] = 1'b0; rv[g] = 1'b0; rd_s[g] = '0;
            return;
        end
        if (prs[g]) begin
            chk("rd_stall_addr", a_s[g], pa[g]);
            chk("rd_stall_read", 32'(r_s[g]), 32'd1);
        end
        if (pws[g]) begin
            chk("wr_stall_addr", a_s[g], pa[g]);
            chk("wr_stall_data", 32'(d_s[g]), 32'(pwd[g]));
            chk("wr_stall_write", 32'(w_s[g]), 32'd1);
        end
        if (r_s[g] || w_s[g]) chk("rd_wr_exclusive", 32'(r_s[g] & w_s[g]), 32'd0);
        rv[g] = 1'b0;
        rd_s[g] = '0;
        if (pc[g] > 0 && pd_due[g][ph[g]] <= cyc) begin
            rv[g] = 1'b1;
            rd_s[g] = pd_dat[g][ph[g]];
            ph[g] = (ph[g] + 1) % 8;
            pc[g]--;
        end
        wq[g] = mode_rand[g] ? 1'($urandom_range(0, 1)) : 1'b0;
        if (r_s[g] && pc[g] >= 3) wq[g] = 1'b1;
        if (r_s[g] && !wq[g]) begin
            lat = mode_rand[g] ? int'($urandom_range(1, 4)) : 1;
            j = (ph[g] + pc[g]) % 8;
            pd_dat[g][j] = mem[g][idx(a_s[g])];
            pd_due[g][j] = cyc + lat;
            pc[g]++;
            n_rd[g]++;
        end
        if (w_s[g] && !wq[g]) begin
            mem[g][idx(a_s[g])] = d_s[g];
            chk("wr_addr_seq", a_s[g], DST + 32'(2 * wr_k[g]));
            wr_k[g]++;
            n_wr[g]++;
        end
        if (spur[g]) begin
            rv[g] = 1'b1;
            rd_s[g] = 16'h5A5A;
        end
        prs[g] = r_s[g] & wq[g];
        pws[g] = w_s[g] & wq[g];
        pa[g]  = a_s[g];
        pwd[g] = d_s[g];
    endtask

    always @(negedge clk) begin
        cyc++;
        a_s[0] = bus0.address; r_s[0] = bus0.read; w_s[0] = bus0.write; d_s[0] = bus0.writedata;
        a_s[1] = bus1.address; r_s[1] = bus1.read; w_s[1] = bus1.write; d_s[1] = bus1.writedata;
        for (int g = 0; g < 2; g++) begin
            if (state_w[g] !== pst[g]) begin
                seq[g] = {seq[g][27:0], state_w[g]};
                pst[g] = state_w[g];
            end
            if (done_w[g] === 1'b1 && pdn[g] !== 1'b1) drise[g]++;
            pdn[g] = done_w[g];
            slave_step(g);
        end
        bus0.waitrequest = wq[0]; bus0.readdatavalid = rv[0]; bus0.readdata = rd_s[0];
        bus1.waitrequest = wq[1]; bus1.readdatavalid = rv[1]; bus1.readdata = rd_s[1];
    end

    task automatic tick(int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic wait_done(int g, string tag);
        int k = 0;
        while (done_w[g] !== 1'b1 && k < 5000) begin
            tick(1);
            k++;
        end
        chk(tag, 32'(done_w[g]), 32'd1);
    endtask

    task automatic run_copy(int g, string tag);
        start_r[g] = 1'b0;
        tick(2);
        wr_k[g] = 0;
        seq[g] = '0;
        start_r[g] = 1'b1;
        tick(1);
        wait_done(g, tag);
    endtask

    task automatic clear_dst(int g);
        for (int i = 0; i < 64; i++) mem[g][1024 + i] = 16'hDEAD;
    endtask

    task automatic check_dst0(string tag);
        for (int i = 0; i < 32; i++) chk(tag, 32'(mem[0][1024 + i]), i);
    endtask

    task automatic check_dst1(string tag);
        logic [15:0] exp1 [5];
        exp1 = '{16'hFFFE, 16'hFFFD, 16'hFFFC, 16'hFFFB, 16'hFFFA};
        for (int i = 0; i < 5; i++) chk(tag, 32'(mem[1][1024 + i]), 32'(exp1[i]));
    endtask

    initial begin
        int r0, w0, d0, k;
        for (int g = 0; g < 2; g++) begin
            rst_r[g] = 1'b1; start_r[g] = 1'b0; mode_rand[g] = 0; spur[g] = 0;
            ph[g] = 0; pc[g] = 0; n_rd[g] = 0; n_wr[g] = 0; wr_k[g] = 0; drise[g] = 0;
            prs[g] = 0; pws[g] = 0; pa[g] = '0; pwd[g] = '0; seq[g] = '0; pst[g] = 4'd0; pdn[g] = 1'b0;
            for (int i = 0; i < 2048; i++) mem[g][i] = '0;
            clear_dst(g);
        end
        for (int i = 0; i < 32; i++) mem[0][i] = 16'(i);
        for (int i = 0; i < 5; i++) mem[1][i] = 16'(i + 1);

        tick(3);
        chk("rst_state", 32'(state_w[0]), 32'd0);
        chk("rst_done", 32'(done_w[0]), 32'd0);
        chk("rst_read", 32'(bus0.read), 32'd0);
        chk("rst_write", 32'(bus0.write), 32'd0);
        chk("rst_address", bus0.address, 32'd0);
        chk("rst_writedata", 32'(bus0.writedata), 32'd0);
        chk("rst_byteenable", 32'(bus0.byteenable), 32'd3);
        rst_r[0] = 1'b0;
        rst_r[1] = 1'b0;
        tick(2);

        // Plain 32-word copy in two full chunks, zero-wait slave.
        r0 = n_rd[0]; w0 = n_wr[0]; d0 = drise[0];
        run_copy(0, "t1_done");
        check_dst0("t1_dst");
        chk("t1_reads", n_rd[0] - r0, 32);
        chk("t1_writes", n_wr[0] - w0, 32);
        chk("t1_done_rises", drise[0] - d0, 1);
        chk("t1_state_seq", seq[0], 32'h0012_1230);
        start_r[0] = 1'b0;

        // XOR copy with a one-word tail chunk.
        r0 = n_rd[1]; w0 = n_wr[1];
        run_copy(1, "t2_done");
        check_dst1("t2_dst");
        chk("t2_reads", n_rd[1] - r0, 5);
        chk("t2_writes", n_wr[1] - w0, 5);
        chk("t2_state_seq", seq[1], 32'h0012_1230);
        start_r[1] = 1'b0;

        // Random stalls and read latency; start stays high afterwards.
        clear_dst(0);
        mode_rand[0] = 1;
        run_copy(0, "t3_done");
        check_dst0("t3_dst");
        mode_rand[0] = 0;

        // Held start must not retrigger; a fresh edge must.
        r0 = n_rd[0];
        tick(1000);
        chk("t4_held_state", 32'(state_w[0]), 32'd0);
        chk("t4_held_reads", n_rd[0] - r0, 0);
        chk("t4_held_done", 32'(done_w[0]), 32'd1);
        start_r[0] = 1'b0;
        tick(2);
        chk("t4_done_before_edge", 32'(done_w[0]), 32'd1);
        clear_dst(0);
        wr_k[0] = 0;
        seq[0] = '0;
        start_r[0] = 1'b1;
        tick(1);
        chk("t4_done_cleared", 32'(done_w[0]), 32'd0);
        chk("t4_state_rd", 32'(state_w[0]), 32'd1);
        wait_done(0, "t4_done");
        check_dst0("t4_dst");

        // Reset in the middle of the write phase.
        clear_dst(0);
        start_r[0] = 1'b0;
        tick(2);
        wr_k[0] = 0;
        w0 = n_wr[0];
        start_r[0] = 1'b1;
        k = 0;
        while (n_wr[0] - w0 < 3 && k < 2000) begin
            tick(1);
            k++;
        end
        tick(1);
        chk("t5_in_wr", 32'(state_w[0]), 32'd2);
        rst_r[0] = 1'b1;
        #1;
        chk("t5_async_read", 32'(bus0.read), 32'd0);
        chk("t5_async_write", 32'(bus0.write), 32'd0);
        chk("t5_async_done", 32'(done_w[0]), 32'd0);
        chk("t5_async_state", 32'(state_w[0]), 32'd0);
        tick(3);
        start_r[0] = 1'b0;
        rst_r[0] = 1'b0;
        clear_dst(0);
        run_copy(0, "t5_done");
        check_dst0("t5_dst");

        // Spurious readdatavalid while idle.
        start_r[1] = 1'b0;
        spur[1] = 1;
        tick(3);
        spur[1] = 0;
        chk("t6_idle", 32'(state_w[1]), 32'd0);
        clear_dst(1);
        run_copy(1, "t6_done");
        check_dst1("t6_dst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/sdram_block_copier.md
Name: sdram_block_copier

Overview:
- Avalon-MM master instantiated inside the Qsys system as the SDRAM master component; its start/done conduit connects to the HPS start/done PIOs.
- On a rising edge of start, it copies NUM_WORDS 16-bit words from SRC_BASE to DST_BASE in SDRAM, XORing each word with XOR_MASK. It works in chunks through an internal CHUNK-deep buffer.
- Signals completion on done. The HPS then reads the destination region or hands it to the video frame reader.

Parameters:
- ADDR_W, 32, Avalon byte-address width.
- DATA_W, 16, data width; must equal the SDRAM width. Byte stride per word = DATA_W/8.
- SRC_BASE, 32'h0000_0000, source byte address.
- DST_BASE, 32'h0010_0000, destination byte address.
- NUM_WORDS, 1024, total words to copy; valid range 1..65535.
- CHUNK, 16, buffer depth in words; must be a power of two, 2..256.
- XOR_MASK, 16'h0000, applied to every word before it is written. 0 gives a plain copy.

Ports:
- clk  in  1  system clock, shared with the SDRAM controller.
- reset  in  1  asynchronous, active-high.
- start  in  1  level from the HPS PIO; a rising edge launches a copy.
- done  out  1  high when a copy completes; held until the next accepted start.
- state  out  4  current FSM state, for debug/HEX.
- avm_address  out  ADDR_W  byte address.
- avm_read  out  1  read request.
- avm_write  out  1  write request.
- avm_writedata  out  DATA_W  write data.
- avm_byteenable  out  DATA_W/8  tied all-ones.
- avm_readdata  in  DATA_W  read data.
- avm_readdatavalid  in  1  read data valid; pipelined reads are supported.
- avm_waitrequest  in  1  slave stall.

Behaviour:
- Reset (async, immediate):
  - State is IDLE; read, write, done, address and writedata are all 0.
  - Edge detector register is 0; word counters and buffer pointers are 0.
- State encoding: IDLE=0, RD=1, WR=2, FIN=3. The state output equals this encoding.
- IDLE:
  - start_q registers start. An accepted start is start & ~start_q, taken in IDLE only.
  - On accept: done<=0, remaining<=NUM_WORDS, rd_ptr<=SRC_BASE, wr_ptr<=DST_BASE, go to RD the next cycle.
- RD:
  - n = min(CHUNK, remaining).
  - Assert avm_read with avm_address = rd_ptr + issued*stride.
  - issued increments only on cycles where avm_read & ~avm_waitrequest. Address and read stay stable while waitrequest is high.
  - Deassert read once issued==n. Reads may be outstanding.
  - Each avm_readdatavalid writes (readdata ^ XOR_MASK) to buf[received] and increments received.
  - When received==n, go to WR.
  - The RD→WR latency depends on the slave; the FSM takes no fixed cycle count.
- WR:
  - avm_write=1, avm_address = wr_ptr + written*stride, avm_writedata = buf[written].
  - Advance written only on ~avm_waitrequest; otherwise hold all outputs.
  - After the write that makes written==n:
    - remaining -= n; rd_ptr += n*stride; wr_ptr += n*stride; clear issued, received and written.
    - If remaining==0, go to FIN; else go to RD.
- FIN: done<=1 and go to IDLE in the same transition. done then stays 1.
- avm_read and avm_write are never asserted together.
- Partial last chunk: if NUM_WORDS is not a multiple of CHUNK, the final chunk is NUM_WORDS mod CHUNK words.
- Start edges outside IDLE are ignored. start held high continuously never retriggers.
- avm_readdatavalid outside RD is ignored; no buffer write occurs.
- Address arithmetic wraps modulo 2^ADDR_W with no error.
- Reset mid-operation: the copy is abandoned immediately. Words already written remain; done=0.
- Counter widths: remaining is 16 bits. issued, received and written are each log2(CHUNK)+1 bits.

Test Plan:
- Plain copy, NUM_WORDS=32, CHUNK=16, XOR_MASK=0, zero-wait slave model, src[i]=i → dst[i]=i for i=0..31. Exactly 32 reads and 32 writes; done rises once; state visits 1,2,1,2,3,0.
- XOR_MASK=16'hFFFF, NUM_WORDS=5, CHUNK=4, src={1,2,3,4,5} → dst={FFFE,FFFD,FFFC,FFFB,FFFA}. The second chunk is 1 word long.
- Random waitrequest (50%) and readdatavalid latency of 1-4 cycles with 3 reads outstanding → data still exact. Address and read/write stay stable during every stall; the write address sequence is DST_BASE+0,2,4,….
- Start held high for 1000 cycles after done, then a second rising edge → no retrigger until the edge. The second edge clears done the cycle after acceptance and re-runs the copy.
- Reset asserted mid-WR (after 3 writes) → read=write=done=0 and state=0 asynchronously. A fresh start edge then completes a full copy correctly.
- Spurious readdatavalid pulse while in IDLE → buffer is not modified; the next copy's dst matches src.
